// File: rtl/spectrum_mmu.sv
// Spectrum 128-style memory manager: CPU clock-enable divider, paging
// register, bank/ROM mapping and a loader that can take over RAM.
module spectrum_mmu #(
    parameter int RAM_BANKS = 8,
    parameter int ROM_PAGES = 2,
    parameter int CLK_DIV   = 8,
    localparam int BB = $clog2(RAM_BANKS),
    localparam int RB = (ROM_PAGES > 2) ? $clog2(ROM_PAGES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   cpu_addr,
    input  logic          cpu_mreq_n,
    input  logic          cpu_iorq_n,
    input  logic          cpu_wr_n,
    input  logic [7:0]    cpu_dout,
    input  logic          ld_start,
    input  logic          ld_stop,
    input  logic          ld_wr,
    input  logic [BB+13:0] ld_addr,
    input  logic [7:0]    ld_data,
    input  logic          ld_page_wr,
    output logic          cpu_ce,
    output logic          loading,
    output logic          rom_cs,
    output logic [RB+13:0] rom_addr,
    output logic          ram_we,
    output logic [BB+13:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic [7:0]    page_reg,
    output logic          screen_bank
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    // A 4-bank build folds the fixed banks 5 and 2 onto 1 and 2.
    localparam logic [BB-1:0] BANK5 = (RAM_BANKS == 4) ? BB'(1) : BB'(5);
    localparam logic [BB-1:0] BANK2 = BB'(2);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        LOAD = 2'd2
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          loading_q;
    logic [7:0]    page_q;
    logic [7:0]    page_d;

    logic          ce_slot;
    logic          ld_mode;
    logic          cpu_pg_wr;
    logic          cpu_ram_wr;
    logic [BB-1:0] pg_bank;
    logic [BB-1:0] cpu_bank;
    logic [RB-1:0] rom_page;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            loading_q <= 1'b0;
        end else begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            unique case (state_q)
                RUN: begin
                    if (ld_start) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // Leave only once the skipped CPU slot has passed.
                    if (cnt_q == LAST) begin
                        state_q   <= LOAD;
                        loading_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_stop) begin
                        state_q   <= RUN;
                        cnt_q     <= '0;
                        loading_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    loading_q <= 1'b0;
                end
            endcase
        end
    end

    assign ce_slot = (cnt_q == LAST);
    assign cpu_ce  = ce_slot && (state_q == RUN);
    assign ld_mode = (state_q == LOAD);
    assign loading = loading_q;

    assign cpu_pg_wr = cpu_ce && !cpu_iorq_n && !cpu_wr_n
                    && !cpu_addr[15] && !cpu_addr[1] && !page_q[5];

    always_comb begin
        page_d = page_q;
        unique case (1'b1)
            ld_mode && ld_page_wr: page_d = ld_data;
            cpu_pg_wr:             page_d = cpu_dout;
            default:               page_d = page_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            page_q <= 8'h00;
        end else begin
            page_q <= page_d;
        end
    end

    assign page_reg    = page_q;
    assign screen_bank = page_q[3];

    assign pg_bank = BB'(page_q[2:0]);

    always_comb begin
        cpu_bank = '0;
        unique case (1'b1)
            cpu_addr[15:14] == 2'b01: cpu_bank = BANK5;
            cpu_addr[15:14] == 2'b10: cpu_bank = BANK2;
            cpu_addr[15:14] == 2'b11: cpu_bank = pg_bank;
            default:                  cpu_bank = '0;
        endcase
    end

    assign rom_page = (ROM_PAGES == 1) ? '0 : RB'(page_q[4]);
    assign rom_addr = {rom_page, cpu_addr[13:0]};
    assign rom_cs   = !cpu_mreq_n && (cpu_addr[15:14] == 2'b00);

    assign cpu_ram_wr = cpu_ce && !cpu_mreq_n && !cpu_wr_n
                     && (cpu_addr[15:14] != 2'b00);

    assign ram_addr = ld_mode ? ld_addr : {cpu_bank, cpu_addr[13:0]};
    assign ram_we   = ld_mode ? ld_wr   : cpu_ram_wr;
    assign ram_din  = ld_mode ? ld_data : cpu_dout;

endmodule

// File: tb/tb_spectrum_mmu.sv
// Directed bench for spectrum_mmu: expectations are queued as stimulus is
// applied and checked against the outputs once they have settled.
module tb_spectrum_mmu;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_mreq_n;
    logic        cpu_iorq_n;
    logic        cpu_wr_n;
    logic [7:0]  cpu_dout;
    logic        ld_start;
    logic        ld_stop;
    logic        ld_wr;
    logic [16:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_page_wr;
    logic        cpu_ce;
    logic        loading;
    logic        rom_cs;
    logic [14:0] rom_addr;
    logic        ram_we;
    logic [16:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  page_reg;
    logic        screen_bank;

    spectrum_mmu #(
        .RAM_BANKS(8),
        .ROM_PAGES(2),
        .CLK_DIV  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_mreq_n (cpu_mreq_n),
        .cpu_iorq_n (cpu_iorq_n),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_dout   (cpu_dout),
        .ld_start   (ld_start),
        .ld_stop    (ld_stop),
        .ld_wr      (ld_wr),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_page_wr (ld_page_wr),
        .cpu_ce     (cpu_ce),
        .loading    (loading),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .page_reg   (page_reg),
        .screen_bank(screen_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {S_CE, S_LD, S_PG, S_SCR, S_WE, S_RA, S_RD, S_RCS, S_ROA} sel_e;
    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   phase  = 0;

    function automatic logic [31:0] observe(sel_e s);
        case (s)
            S_CE:    return {31'd0, cpu_ce};
            S_LD:    return {31'd0, loading};
            S_PG:    return {24'd0, page_reg};
            S_SCR:   return {31'd0, screen_bank};
            S_WE:    return {31'd0, ram_we};
            S_RA:    return {15'd0, ram_addr};
            S_RD:    return {24'd0, ram_din};
            S_RCS:   return {31'd0, rom_cs};
            S_ROA:   return {17'd0, rom_addr};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_v(input string tag, input sel_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] o;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sel);
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        phase = (phase + 1) % 8;
    endtask

    task automatic idle();
        cpu_addr   = 16'h0000;
        cpu_mreq_n = 1'b1;
        cpu_iorq_n = 1'b1;
        cpu_wr_n   = 1'b1;
        cpu_dout   = 8'h00;
    endtask

    task automatic wait_phase(input int k);
        for (int i = 0; i < 8 && phase != k; i++) step();
    endtask

    task automatic cpu_out(input logic [15:0] a, input logic [7:0] d);
        wait_phase(7);
        cpu_addr   = a;
        cpu_dout   = d;
        cpu_iorq_n = 1'b0;
        cpu_wr_n   = 1'b0;
        expect_v("out_ce", S_CE, 32'd1);
        expect_v("out_no_ram_we", S_WE, 32'd0);
        drain();
        step();
        idle();
    endtask

    task automatic mem_rd(input logic [15:0] a);
        step();
        cpu_addr   = a;
        cpu_mreq_n = 1'b0;
        cpu_wr_n   = 1'b1;
    endtask

    initial begin
        idle();
        reset      = 1'b1;
        ld_start   = 1'b0;
        ld_stop    = 1'b0;
        ld_wr      = 1'b0;
        ld_addr    = '0;
        ld_data    = 8'h00;
        ld_page_wr = 1'b0;
        step();
        step();
        expect_v("rst_loading", S_LD, 32'd0);
        expect_v("rst_page", S_PG, 32'h00);
        expect_v("rst_ce", S_CE, 32'd0);
        expect_v("rst_we", S_WE, 32'd0);
        expect_v("rst_screen", S_SCR, 32'd0);
        drain();

        // Divider: pulses at cycles 7, 15, 23, 31 after reset.
        reset = 1'b0;
        phase = 0;
        for (int i = 0; i < 32; i++) begin
            expect_v("div_ce", S_CE, (i % 8 == 7) ? 32'd1 : 32'd0);
            drain();
            step();
        end

        // Paging write and bank/ROM mapping.
        cpu_out(16'h7FFD, 8'h13);
        expect_v("pg_13", S_PG, 32'h13);
        expect_v("pg_13_scr", S_SCR, 32'd0);
        drain();
        cpu_out(16'h7FFF, 8'h01);
        expect_v("pg_a1_ignored", S_PG, 32'h13);
        drain();
        cpu_out(16'hFFFD, 8'h01);
        expect_v("pg_a15_ignored", S_PG, 32'h13);
        drain();
        mem_rd(16'hC123);
        expect_v("map_c123", S_RA, 32'h0C123);
        expect_v("map_c123_rcs", S_RCS, 32'd0);
        drain();
        mem_rd(16'h4123);
        expect_v("map_4123", S_RA, 32'h14123);
        drain();
        mem_rd(16'h8123);
        expect_v("map_8123", S_RA, 32'h08123);
        drain();
        mem_rd(16'h0123);
        expect_v("rom_cs", S_RCS, 32'd1);
        expect_v("rom_pg1", S_ROA, 32'h4123);
        drain();

        // CPU RAM write only in the enable slot; ROM writes dropped.
        wait_phase(6);
        cpu_addr   = 16'hC010;
        cpu_mreq_n = 1'b0;
        cpu_wr_n   = 1'b0;
        cpu_dout   = 8'h5A;
        expect_v("wr_no_ce", S_WE, 32'd0);
        drain();
        step();
        expect_v("wr_we", S_WE, 32'd1);
        expect_v("wr_addr", S_RA, 32'h0C010);
        expect_v("wr_din", S_RD, 32'h5A);
        drain();
        cpu_addr = 16'h0010;
        expect_v("wr_rom_drop", S_WE, 32'd0);
        drain();
        step();
        idle();

        // Lock bit.
        cpu_out(16'h7FFD, 8'h20);
        expect_v("lock_set", S_PG, 32'h20);
        drain();
        mem_rd(16'h0123);
        expect_v("rom_pg0", S_ROA, 32'h0123);
        drain();
        idle();
        cpu_out(16'h7FFD, 8'h07);
        expect_v("lock_hold", S_PG, 32'h20);
        drain();

        // Loader handover starting at count 2.
        wait_phase(2);
        ld_start = 1'b1;
        expect_v("hold_ce0", S_CE, 32'd0);
        expect_v("hold_ld0", S_LD, 32'd0);
        drain();
        step();
        ld_start = 1'b0;
        for (int k = 3; k < 8; k++) begin
            expect_v("hold_ce", S_CE, 32'd0);
            expect_v("hold_ld", S_LD, 32'd0);
            drain();
            step();
        end
        expect_v("load_ld", S_LD, 32'd1);
        expect_v("load_ce", S_CE, 32'd0);
        drain();
        ld_wr      = 1'b1;
        ld_addr    = 17'h14000;
        ld_data    = 8'hAA;
        cpu_addr   = 16'hC000;
        cpu_mreq_n = 1'b0;
        cpu_wr_n   = 1'b0;
        cpu_dout   = 8'h55;
        expect_v("ld_we", S_WE, 32'd1);
        expect_v("ld_addr", S_RA, 32'h14000);
        expect_v("ld_din", S_RD, 32'hAA);
        drain();
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        ld_wr    = 1'b0;
        for (int i = 0; i < 9; i++) begin
            expect_v("load_stay", S_LD, 32'd1);
            expect_v("load_no_ce", S_CE, 32'd0);
            expect_v("load_cpu_no_we", S_WE, 32'd0);
            drain();
            step();
        end
        ld_page_wr = 1'b1;
        ld_data    = 8'h07;
        step();
        ld_page_wr = 1'b0;
        expect_v("ld_page_unlock", S_PG, 32'h07);
        drain();
        idle();
        ld_stop = 1'b1;
        step();
        ld_stop = 1'b0;
        phase   = 0;
        for (int i = 0; i < 8; i++) begin
            expect_v("stop_ce", S_CE, (i == 7) ? 32'd1 : 32'd0);
            expect_v("stop_ld", S_LD, 32'd0);
            drain();
            step();
        end

        // Loader-only controls ignored in RUN.
        ld_page_wr = 1'b1;
        ld_data    = 8'h08;
        step();
        ld_page_wr = 1'b0;
        ld_stop    = 1'b1;
        step();
        ld_stop = 1'b0;
        expect_v("run_ld_page_ign", S_PG, 32'h07);
        drain();
        cpu_out(16'h7FFD, 8'h18);
        expect_v("pg_18", S_PG, 32'h18);
        expect_v("scr_1", S_SCR, 32'd1);
        drain();
        mem_rd(16'h0000);
        expect_v("rom_pg1_b", S_ROA, 32'h4000);
        drain();
        idle();

        // Reset in the middle of a load.
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        for (int i = 0; i < 16 && loading !== 1'b1; i++) step();
        expect_v("load2_ld", S_LD, 32'd1);
        drain();
        ld_page_wr = 1'b1;
        ld_data    = 8'h2D;
        step();
        ld_page_wr = 1'b0;
        expect_v("load2_pg", S_PG, 32'h2D);
        expect_v("load2_scr", S_SCR, 32'd1);
        drain();
        ld_wr   = 1'b1;
        ld_addr = 17'h1FFFF;
        ld_data = 8'h33;
        expect_v("load2_we", S_WE, 32'd1);
        drain();
        reset = 1'b1;
        step();
        expect_v("abort_we", S_WE, 32'd0);
        expect_v("abort_ld", S_LD, 32'd0);
        expect_v("abort_pg", S_PG, 32'h00);
        expect_v("abort_scr", S_SCR, 32'd0);
        expect_v("abort_ce", S_CE, 32'd0);
        drain();
        reset = 1'b0;
        phase = 0;
        step();
        expect_v("after_we", S_WE, 32'd0);
        expect_v("after_ld", S_LD, 32'd0);
        drain();
        ld_wr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
